// File: rtl/tetris_piece_ctrl.sv
// Falling-tetromino sequencer and 8-column playfield occupancy map for the vga renderer.
// Build option: define HARD_DROP_EN to add the DROP state driven by the drop pulse.
module tetris_piece_ctrl #(
  parameter int unsigned ROWS    = 20,
  parameter int unsigned SPAWN_X = 3
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              start,
  input  logic              tick,
  input  logic              move_left,
  input  logic              move_right,
  input  logic              drop,
  input  logic [2:0]        piece_sel,
  output logic [2:0]        block1_x,
  output logic [2:0]        block2_x,
  output logic [2:0]        block3_x,
  output logic [2:0]        block4_x,
  output logic [4:0]        block1_y,
  output logic [4:0]        block2_y,
  output logic [4:0]        block3_y,
  output logic [4:0]        block4_y,
  output logic [8*ROWS-1:0] map_out,
  output logic [7:0]        lines,
  output logic              game_over,
  output logic              busy
);

  localparam int unsigned MW = 8 * ROWS;
  localparam int unsigned IW = $clog2(MW);
  localparam logic [4:0]  DM1 = 5'h1f;
  localparam logic [4:0]  D0  = 5'h00;
  localparam logic [4:0]  D1  = 5'h01;
  localparam logic [4:0]  D2  = 5'h02;

  // Candidate cells: x is two's complement so a step off the left edge shows up as negative
  typedef logic [3:0][4:0] xv_t;
  typedef logic [3:0][5:0] yv_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_ACTIVE, S_LOCK, S_SCAN, S_SHIFT, S_GAME_OVER
`ifdef HARD_DROP_EN
    , S_DROP
`endif
  } state_t;

  function automatic xv_t shape_dx(input logic [2:0] s);
    case (s)
      3'd0:    return {D2, D1, D0, DM1};
      3'd2:    return {D0, D1, D0, DM1};
      3'd3:    return {DM1, D1, D0, DM1};
      3'd4:    return {D1, D1, D0, DM1};
      3'd5:    return {D0, DM1, D1, D0};
      3'd6:    return {D1, D0, D0, DM1};
      default: return {D1, D0, D1, D0};
    endcase
  endfunction

  function automatic logic [3:0] shape_dy(input logic [2:0] s);
    case (s)
      3'd0:                return 4'b0000;
      3'd2, 3'd3, 3'd4:    return 4'b1000;
      default:             return 4'b1100;
    endcase
  endfunction

  function automatic logic cells_legal(input xv_t cx, input yv_t cy, input logic [MW-1:0] map);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cx[i][4:3] != 2'b00 || cy[i] >= 6'(ROWS)) ok = 1'b0;
      else if (map[IW'({cy[i][4:0], cx[i][2:0]})]) ok = 1'b0;
    end
    return ok;
  endfunction

  state_t          state_q, state_d;
  logic [MW-1:0]   map_q, map_d;
  logic [3:0][2:0] bx_q, bx_d;
  logic [3:0][4:0] by_q, by_d;
  logic [4:0]      ptr_q, ptr_d;
  logic [7:0]      lines_q, lines_d;
  logic            busy_q, busy_d;
  logic            game_over_q, game_over_d;

  xv_t           sp_dx, sp_x, dn_x, mv_x;
  yv_t           sp_y, dn_y, mv_y;
  logic [3:0]    sp_dy;
  logic          sp_ok, dn_ok, mv_ok, row_full;
  logic [MW-1:0] lock_mask, shifted;

`ifndef HARD_DROP_EN
  logic unused_drop;
  assign unused_drop = drop;
`endif

  // Candidate positions, lock mask and row-clear image, all derived from current state
  always_comb begin
    sp_dx     = shape_dx(piece_sel);
    sp_dy     = shape_dy(piece_sel);
    sp_x      = '0;
    sp_y      = '0;
    dn_x      = '0;
    dn_y      = '0;
    mv_x      = '0;
    mv_y      = '0;
    lock_mask = '0;
    for (int i = 0; i < 4; i++) begin
      sp_x[i] = 5'(SPAWN_X) + sp_dx[i];
      sp_y[i] = {5'd0, sp_dy[i]};
      dn_x[i] = {2'b00, bx_q[i]};
      dn_y[i] = {1'b0, by_q[i]} + 6'd1;
      mv_x[i] = move_left ? ({2'b00, bx_q[i]} - 5'd1) : ({2'b00, bx_q[i]} + 5'd1);
      mv_y[i] = {1'b0, by_q[i]};
      lock_mask[IW'({by_q[i], bx_q[i]})] = 1'b1;
    end
    sp_ok    = cells_legal(sp_x, sp_y, map_q);
    dn_ok    = cells_legal(dn_x, dn_y, map_q);
    mv_ok    = cells_legal(mv_x, mv_y, map_q);
    row_full = (map_q[IW'({ptr_q, 3'b000}) +: 8] == 8'hff);
    shifted      = map_q;
    shifted[7:0] = 8'h00;
    for (int r = 1; r < int'(ROWS); r++) begin
      if (5'(r) <= ptr_q) shifted[r*8 +: 8] = map_q[(r-1)*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    bx_d    = bx_q;
    by_d    = by_q;
    ptr_d   = ptr_q;
    lines_d = lines_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          map_d   = '0;
          lines_d = 8'd0;
          state_d = S_SPAWN;
        end
      end
      S_SPAWN: begin
        for (int i = 0; i < 4; i++) begin
          bx_d[i] = sp_x[i][2:0];
          by_d[i] = sp_y[i][4:0];
        end
        state_d = sp_ok ? S_ACTIVE : S_GAME_OVER;
      end
      S_ACTIVE: begin
        if (tick) begin
          if (dn_ok) begin
            for (int i = 0; i < 4; i++) by_d[i] = dn_y[i][4:0];
          end else begin
            state_d = S_LOCK;
          end
        end
`ifdef HARD_DROP_EN
        else if (drop) state_d = S_DROP;
`endif
        else if ((move_left ^ move_right) && mv_ok) begin
          for (int i = 0; i < 4; i++) bx_d[i] = mv_x[i][2:0];
        end
      end
`ifdef HARD_DROP_EN
      S_DROP: begin
        if (dn_ok) begin
          for (int i = 0; i < 4; i++) by_d[i] = dn_y[i][4:0];
        end else begin
          state_d = S_LOCK;
        end
      end
`endif
      S_LOCK: begin
        map_d   = map_q | lock_mask;
        ptr_d   = 5'(ROWS - 1);
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (row_full)           state_d = S_SHIFT;
        else if (ptr_q == 5'd0) state_d = S_SPAWN;
        else                    ptr_d   = ptr_q - 5'd1;
      end
      S_SHIFT: begin
        map_d   = shifted;
        lines_d = lines_q + 8'd1;
        state_d = S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d == S_LOCK) || (state_d == S_SCAN) ||
                  (state_d == S_SHIFT) || (state_d == S_SPAWN);
    game_over_d = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q     <= S_IDLE;
      map_q       <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      ptr_q       <= 5'd0;
      lines_q     <= 8'd0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      map_q       <= map_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      ptr_q       <= ptr_d;
      lines_q     <= lines_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign block1_x  = bx_q[0];
  assign block2_x  = bx_q[1];
  assign block3_x  = bx_q[2];
  assign block4_x  = bx_q[3];
  assign block1_y  = by_q[0];
  assign block2_y  = by_q[1];
  assign block3_y  = by_q[2];
  assign block4_y  = by_q[3];
  assign map_out   = map_q;
  assign lines     = lines_q;
  assign game_over = game_over_q;
  assign busy      = busy_q;

endmodule
